// File: rtl/tb_pkg.sv
// Shared constants and types for the operand_driver stimulus generator:
// LFSR polynomial, default seeds, control-state enum and LFSR helpers.
package tb_pkg;

    localparam logic [31:0] LFSR_POLY      = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED_A = 32'h0000_0001;
    localparam logic [31:0] DEFAULT_SEED_B = 32'hACE1_2468;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_e;

    // Galois right-shift step for x^32+x^22+x^2+x+1
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

    // An all-zero LFSR never leaves zero, so substitute 1
    function automatic logic [31:0] seed_fix(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

endpackage

// File: rtl/operand_driver_if.sv
// Beat bus from operand_driver to the DUT input stage / scoreboard.
// The master drives operands and valid; the slave returns ready.
interface operand_driver_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] o_dut_a;
    logic [WIDTH-1:0] o_dut_b;
    logic             o_valid;
    logic             i_ready;

    modport master (
        output o_dut_a,
        output o_dut_b,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_dut_a,
        input  o_dut_b,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/operand_driver_lfsr32.sv
// 32-bit Galois LFSR with step enable; resets to its (zero-fixed) seed.
module lfsr32
    import tb_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED_A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_en,
    output logic [31:0] state
);

    logic [31:0] s_q;
    logic [31:0] s_d;

    always_comb begin
        s_d = s_q;
        if (step_en) s_d = lfsr_next(s_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) s_q <= seed_fix(SEED);
        else     s_q <= s_d;
    end

    assign state = s_q;

endmodule

// File: rtl/operand_driver.sv
// Operand-pair beat generator: LFSR or manual source, set/clear filter, valid/ready out.
// Define OPERAND_DRIVER_STALL_CTR_EN to add the o_stall_ctr backpressure counter.
module operand_driver
    import tb_pkg::*;
#(
    parameter int          WIDTH  = 32,
    parameter logic [31:0] SEED_A = DEFAULT_SEED_A,
    parameter logic [31:0] SEED_B = DEFAULT_SEED_B
) (
    input  logic                 clk_dut,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 freeze,
    input  logic                 i_fselect,
    input  logic [WIDTH-1:0]     i_fmanual_a,
    input  logic [WIDTH-1:0]     i_fmanual_b,
    input  logic [WIDTH-1:0]     i_fbitset_a,
    input  logic [WIDTH-1:0]     i_fbitset_b,
    input  logic [WIDTH-1:0]     i_fbitclr_a,
    input  logic [WIDTH-1:0]     i_fbitclr_b,
    operand_driver_if.master     bus,
    output logic [31:0]          o_gen_ctr
`ifdef OPERAND_DRIVER_STALL_CTR_EN
    ,
    output logic [31:0]          o_stall_ctr
`endif
);

    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] dut_a_q, dut_a_d;
    logic [WIDTH-1:0] dut_b_q, dut_b_d;
    logic [31:0]      gen_ctr_q, gen_ctr_d;
    logic [31:0]      lfsr_a, lfsr_b;
    logic [WIDTH-1:0] raw_a, raw_b, filt_a, filt_b;
    logic             load, xfer, lfsr_step;

    lfsr32 #(.SEED(SEED_A)) u_lfsr_a (
        .clk     (clk_dut),
        .rst     (reset),
        .step_en (lfsr_step),
        .state   (lfsr_a)
    );

    lfsr32 #(.SEED(SEED_B)) u_lfsr_b (
        .clk     (clk_dut),
        .rst     (reset),
        .step_en (lfsr_step),
        .state   (lfsr_b)
    );

    // Clear is applied last so it wins over set
    always_comb begin
        raw_a  = i_fselect ? i_fmanual_a : lfsr_a[WIDTH-1:0];
        raw_b  = i_fselect ? i_fmanual_b : lfsr_b[WIDTH-1:0];
        filt_a = (raw_a | i_fbitset_a) & ~i_fbitclr_a;
        filt_b = (raw_b | i_fbitset_b) & ~i_fbitclr_b;
    end

    // Gating load on enable/freeze too keeps a same-cycle freeze or disable
    // from slipping one last beat out.
    always_comb begin
        xfer      = valid_q & bus.i_ready;
        load      = (state_q == RUN) & enable & ~freeze & (~valid_q | bus.i_ready);
        lfsr_step = load & ~i_fselect;
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        dut_a_d   = dut_a_q;
        dut_b_d   = dut_b_q;
        gen_ctr_d = gen_ctr_q + {31'd0, xfer};

        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (!freeze) state_d = RUN;
                RUN:     if (freeze)  state_d = FROZEN;
                FROZEN:  if (!freeze) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end

        if (!enable) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            dut_a_d = filt_a;
            dut_b_d = filt_b;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_dut or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            dut_a_q   <= '0;
            dut_b_q   <= '0;
            gen_ctr_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            dut_a_q   <= dut_a_d;
            dut_b_q   <= dut_b_d;
            gen_ctr_q <= gen_ctr_d;
        end
    end

`ifdef OPERAND_DRIVER_STALL_CTR_EN
    logic [31:0] stall_ctr_q, stall_ctr_d;

    always_comb begin
        stall_ctr_d = stall_ctr_q + {31'd0, valid_q & ~bus.i_ready};
    end

    always_ff @(posedge clk_dut or posedge reset) begin
        if (reset) stall_ctr_q <= 32'd0;
        else       stall_ctr_q <= stall_ctr_d;
    end

    assign o_stall_ctr = stall_ctr_q;
`endif

    assign bus.o_dut_a = dut_a_q;
    assign bus.o_dut_b = dut_b_q;
    assign bus.o_valid = valid_q;
    assign o_gen_ctr   = gen_ctr_q;

endmodule

// File: doc/operand_driver.md
# operand_driver

Stimulus generator between the host-visible control/filter registers and the arithmetic DUT. Each accepted beat carries a pair of WIDTH-bit operands. The raw value for each operand comes from a free-running LFSR or from a host-programmed manual value, then passes through bit-set and bit-clear masks. Beats are delivered over a valid/ready handshake to the DUT input stage and scoreboard, and a 32-bit beat counter feeds the data-count path.

## Interface
- WIDTH, 32: operand width; legal range 1..32.
- SEED_A, 32'h0000_0001: operand A LFSR seed. 0 is replaced by 1.
- SEED_B, 32'hACE1_2468: operand B LFSR seed. 0 is replaced by 1.

- clk_dut  in  1  DUT-domain clock; the only clock.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  level; run generator.
- freeze  in  1  level; stop issuing new beats.
- i_fselect  in  1  1 = manual operands, 0 = LFSR operands.
- i_fmanual_a / i_fmanual_b  in  WIDTH  manual operand values.
- i_fbitset_a / i_fbitset_b  in  WIDTH  bits forced to 1.
- i_fbitclr_a / i_fbitclr_b  in  WIDTH  bits forced to 0.
- o_dut_a / o_dut_b  out  WIDTH  registered operands.
- o_valid  out  1  beat present.
- i_ready  in  1  downstream accepts the beat.
- o_gen_ctr  out  32  count of accepted beats.

## Operation
- State machine:
  - IDLE: o_valid = 0.
  - IDLE → RUN when enable = 1 and freeze = 0.
  - RUN → FROZEN when freeze = 1.
  - FROZEN → RUN when freeze = 0.
  - Any state → IDLE when enable = 0 (highest priority).
- LFSR, per operand, 32-bit Galois right-shift, polynomial x^32+x^22+x^2+x+1:
  - Step rule: next = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 0).
  - The operand uses s[WIDTH-1:0].
  - The LFSR steps only when it sources a load while i_fselect = 0.
- Filter: out = ((fselect ? manual : lfsr) | bitset) & ~bitclr. Clear wins over set.
- Load condition: state = RUN and (o_valid = 0 or i_ready = 1). On load, o_dut_a/b ← filtered values and o_valid ← 1.
- Transfer is o_valid & i_ready. Each transfer increments o_gen_ctr, which wraps 0xFFFF_FFFF → 0.
- While o_valid = 1 and i_ready = 0, o_dut_a/b hold stable. Filter input changes are ignored until the next load.
- FROZEN: no loads. A pending beat stays valid until accepted, then o_valid → 0. The LFSRs and o_gen_ctr hold.
- enable = 0: o_valid → 0 on the next edge and any pending beat is dropped. LFSR state and o_gen_ctr are retained. Only reset reseeds the LFSRs and clears the counter.

## Timing
- Reset values:
  - o_dut_a = 0, o_dut_b = 0.
  - o_valid = 0.
  - o_gen_ctr = 0.
  - LFSRs = seeds (0 replaced by 1).
  - State = IDLE.
- The first beat appears 2 edges after enable rises: edge 1 moves IDLE → RUN, edge 2 loads. The first beat carries the seed values.
- With i_ready held at 1, one beat is produced per cycle.
- o_gen_ctr updates on the edge that completes the transfer.
- freeze and transfer in the same cycle: the transfer completes and counts, and no new load occurs.
- Reset asserted mid-beat clears everything immediately (asynchronous). The LFSRs restart from the seeds.

## Configuration
- OPERAND_DRIVER_STALL_CTR_EN defined:
  - Adds output o_stall_ctr, 32 bits, reset 0.
  - It increments each cycle that o_valid = 1 and i_ready = 0, and wraps.
  - It clears together with o_gen_ctr only on reset.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package tb_pkg holds:
  - the LFSR polynomial constant LFSR_POLY = 32'h8020_0003;
  - the default seeds;
  - the state enum {IDLE, RUN, FROZEN}.
- Sub-module lfsr32 (step-enable, seed parameter, asynchronous reset), instantiated twice.

## Test plan
- LFSR sequence: SEED_A = 1, WIDTH = 32, fselect = 0, masks = 0, ready = 1, enable rises → beat A0 = 0x0000_0001 and A1 = 0x8020_0003. For B, beat B0 = 0xACE1_2468 and B1 = 0x5670_9234.
- Filters: fselect = 1, manual_a = 0x0000_00F0, bitset_a = 0x0000_000F, bitclr_a = 0x0000_0080 → o_dut_a = 0x0000_007F. Same bit in both set and clear → that bit is 0.
- Backpressure: hold ready = 0 for 5 cycles with a beat valid → operands stable and o_gen_ctr unchanged. Release → count +1 and next LFSR value issued. With OPERAND_DRIVER_STALL_CTR_EN defined, o_stall_ctr = 5.
- Freeze: assert freeze while a beat is pending and ready = 0 → beat held. Raise ready → 1 transfer, o_valid drops, no further beats. Deassert freeze → sequence resumes without skipping any LFSR value.
- Disable and reset: drop enable with a beat pending → o_valid = 0 next edge and the counter is unchanged. Re-enable → the next unused LFSR value is issued. Assert reset mid-run → all outputs 0 and the sequence restarts at the seeds.
- Counter wrap: force o_gen_ctr to 0xFFFF_FFFF, complete 1 transfer → 0x0000_0000.
